// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle add/subtract, one 4-bit carry-lookahead slice per clock, LS nibble first
module cla_seq_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ov
);
   localparam int N  = WIDTH / 4;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, acc, acc_nx;
   logic [CW-1:0] cnt;
   logic cry, accept, last;
   logic [3:0] an, bn, g, p, sum;
   logic [4:0] c;
   assign accept = start && state != EXEC;
   assign last   = cnt == CW'(N - 1);
   assign busy   = state == EXEC;
   assign done   = state == DONE;
   assign an     = 4'(a_r >> {cnt, 2'b00});
   assign bn     = 4'(b_r >> {cnt, 2'b00});
   assign g      = an & bn;
   assign p      = an ^ bn;
   // lookahead carries: every slice carry is a flat function of g, p and the carry register
   assign c[0] = cry;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);
   assign sum  = p ^ c[3:0];
   assign acc_nx = (acc & ~(WIDTH'(4'hF) << {cnt, 2'b00})) | (WIDTH'(sum) << {cnt, 2'b00});
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = state == EXEC ? (last ? DONE : EXEC) : (start ? EXEC : IDLE);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         a_r <= '0;
         b_r <= '0;
         acc <= '0;
         cnt <= '0;
         cry <= 1'b0;
         s   <= '0;
         co  <= 1'b0;
         ov  <= 1'b0;
      end else if (accept) begin
         a_r <= a;
         b_r <= op ? ~b : b;
         cry <= op | ci;
         cnt <= '0;
      end else if (busy) begin
         acc <= acc_nx;
         cry <= c[4];
         cnt <= cnt + 1'b1;
         if (last) begin
            s  <= acc_nx;
            co <= c[4];
            ov <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (acc_nx[WIDTH-1] != a_r[WIDTH-1]);
         end
      end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed scoreboard bench for 8- and 32-bit cla_seq_adder instances
module tb_cla_seq_adder;
   typedef struct packed {logic [31:0] s; logic co; logic ov;} exp_t;
   logic clk = 0, reset_n = 0;
   logic start8 = 0, op8 = 0, ci8 = 0, busy8, done8, co8, ov8;
   logic [7:0] a8 = 0, b8 = 0, s8;
   logic start32 = 0, op32 = 0, ci32 = 0, busy32, done32, co32, ov32;
   logic [31:0] a32 = 0, b32 = 0, s32;
   exp_t q8[$], q32[$];
   int vecs = 0, errs = 0;
   always #5 clk = ~clk;
   cla_seq_adder #(.WIDTH(8)) dut8 (.clk(clk), .reset_n(reset_n), .start(start8), .op(op8), .a(a8), .b(b8),
      .ci(ci8), .busy(busy8), .done(done8), .s(s8), .co(co8), .ov(ov8));
   cla_seq_adder #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .start(start32), .op(op32), .a(a32), .b(b32),
      .ci(ci32), .busy(busy32), .done(done32), .s(s32), .co(co32), .ov(ov32));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic exp_t model(input int w, input logic o, input logic [31:0] x, input logic [31:0] y, input logic c);
      exp_t r;
      logic [32:0] mask, t;
      logic [31:0] be;
      mask = (33'd1 << w) - 33'd1;
      be = (o ? ~y : y) & mask[31:0];
      t = {1'b0, x & mask[31:0]} + {1'b0, be} + {32'd0, o | c};
      r.s = t[31:0] & mask[31:0];
      r.co = t[w];
      r.ov = (x[w-1] == be[w-1]) && (r.s[w-1] != x[w-1]);
      return r;
   endfunction
   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         if (q8.size() == 0) chk("done8_unexpected", done8, 0);
         else begin
            e = q8.pop_front();
            chk("s8", s8, e.s[7:0]);
            chk("co8", co8, e.co);
            chk("ov8", ov8, e.ov);
         end
      end
      if (done32) begin
         if (q32.size() == 0) chk("done32_unexpected", done32, 0);
         else begin
            e = q32.pop_front();
            chk("s32", s32, e.s);
            chk("co32", co32, e.co);
            chk("ov32", ov32, e.ov);
         end
      end
   end
   task automatic drive(input bit w32, input logic o, input logic [31:0] x, input logic [31:0] y, input logic c);
      if (w32) begin
         start32 = 1; op32 = o; a32 = x; b32 = y; ci32 = c;
         q32.push_back(model(32, o, x, y, c));
      end else begin
         start8 = 1; op8 = o; a8 = x[7:0]; b8 = y[7:0]; ci8 = c;
         q8.push_back(model(8, o, x, y, c));
      end
   endtask
   task automatic wait_done(input bit w32, input int n0, input int lat);
      int n = n0;
      while (!(w32 ? done32 : done8) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(w32 ? "latency32" : "latency8", n, lat);
   endtask
   task automatic run(input bit w32, input logic o, input logic [31:0] x, input logic [31:0] y, input logic c);
      drive(w32, o, x, y, c);
      @(posedge clk); #1;
      start8 = 0; start32 = 0;
      wait_done(w32, 0, w32 ? 8 : 2);
      @(posedge clk); #1;
   endtask
   initial begin
      int seen;
      start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); op8 = 1'($urandom);
      start32 = 1'($urandom); a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom); op32 = 1'($urandom);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s8", s8, 0); chk("rst_co8", co8, 0); chk("rst_ov8", ov8, 0);
      chk("rst_busy8", busy8, 0); chk("rst_done8", done8, 0);
      chk("rst_s32", s32, 0); chk("rst_co32", co32, 0); chk("rst_ov32", ov32, 0);
      chk("rst_busy32", busy32, 0); chk("rst_done32", done32, 0);
      start8 = 0; start32 = 0; op8 = 0; op32 = 0;
      reset_n = 1;
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         seen += int'(done8) + int'(done32);
      end
      chk("idle_no_done", seen, 0);
      // 8-bit add and subtract
      drive(0, 0, 32'h37, 32'h59, 0);
      @(posedge clk); #1;
      start8 = 0;
      chk("busy8_c1", busy8, 1);
      @(posedge clk); #1;
      chk("busy8_c2", busy8, 1);
      wait_done(0, 1, 2);
      chk("busy8_done", busy8, 0);
      @(posedge clk); #1;
      chk("done8_pulse", done8, 0);
      run(0, 0, 32'hFF, 32'hFF, 1);
      run(0, 1, 32'h05, 32'h07, 1);
      run(0, 1, 32'h80, 32'h01, 0);
      // 32-bit carry chain
      run(1, 0, 32'hFFFF_FFFF, 32'h1, 0);
      run(1, 1, 32'h1234_5678, 32'h8765_4321, 0);
      // start pulse and operand change during EXEC are ignored
      drive(0, 0, 32'h12, 32'h34, 1);
      @(posedge clk); #1;
      a8 = 8'hFF; b8 = 8'hFF; op8 = 1;
      @(posedge clk); #1;
      start8 = 0;
      wait_done(0, 1, 2);
      @(posedge clk); #1;
      op8 = 0;
      // start held high: one result every N+1 cycles
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'(k & 1), 32'(8'h3C + 8'(k * 45)), 32'(8'hA7 - 8'(k * 29)), 1'(k >> 1));
         @(posedge clk); #1;
         if (k == 3) start8 = 0;
         wait_done(0, 0, 2);
      end
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 32'hFFFF_FFF0 + 32'(k), 32'h0000_0010 * 32'(k + 1), 1'(k));
         @(posedge clk); #1;
         if (k == 2) start32 = 0;
         wait_done(1, 0, 8);
      end
      @(posedge clk); #1;
      // asynchronous reset at cnt=1 aborts the operation
      start32 = 1; op32 = 0; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; ci32 = 1;
      @(posedge clk); #1;
      start32 = 0;
      @(posedge clk); #1;
      chk("abort_busy_before", busy32, 1);
      #1 reset_n = 0;
      #1;
      chk("abort_busy32", busy32, 0); chk("abort_done32", done32, 0);
      chk("abort_s32", s32, 0); chk("abort_co32", co32, 0); chk("abort_ov32", ov32, 0);
      chk("abort_s8", s8, 0);
      @(posedge clk); #1;
      reset_n = 1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         seen += int'(done32);
      end
      chk("abort_no_done", seen, 0);
      run(1, 0, 32'h0000_0010, 32'h0000_0001, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("q8_drained", q8.size(), 0);
      chk("q32_drained", q32.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
